register_read_stage: RTL and testbench

Operand-fetch pipeline stage between instruction decode and execute. Drives the physical register file's two read addresses from the decoded instruction and bypasses same-cycle writeback data. A per-register scoreboard tracks pending destination writes and stalls dependent instructions. Registers the operands and control into a valid/ready output slot for the execute stage.

---
 rtl/register_read_stage.sv | 138 +++++++++++++
 tb/tb_register_read_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_read_stage.sv
// Operand-fetch stage: register file read addressing, writeback bypass,
// per-register pending-write scoreboard and a registered valid/ready output slot.
module register_read_stage #(
  parameter int unsigned DIR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIR_WIDTH-1:0]  in_rs1,
  input  logic [DIR_WIDTH-1:0]  in_rs2,
  input  logic                  in_use_rs1,
  input  logic                  in_use_rs2,
  input  logic [DIR_WIDTH-1:0]  in_rd,
  input  logic                  in_rd_we,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic [DIR_WIDTH-1:0]  read_dir1,
  output logic [DIR_WIDTH-1:0]  read_dir2,
  input  logic [DATA_WIDTH-1:0] read_data1,
  input  logic [DATA_WIDTH-1:0] read_data2,
  input  logic                  wb_en,
  input  logic [DIR_WIDTH-1:0]  wb_dir,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rs1_data,
  output logic [DATA_WIDTH-1:0] out_rs2_data,
  output logic [DIR_WIDTH-1:0]  out_rd,
  output logic                  out_rd_we,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [15:0]           stall_cycles
);

  localparam int unsigned NUM_REGS  = 1 << DIR_WIDTH;
  localparam int unsigned CNT_WIDTH = 16;

  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;
  logic [DIR_WIDTH-1:0]  rd_q, rd_d;
  logic                  rd_we_q, rd_we_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;

  logic                  wb_live, hit_rs1, hit_rs2, hit_rd;
  logic                  raw_hazard, waw_hazard, hazard, space, accept;
  logic [DATA_WIDTH-1:0] rs1_operand, rs2_operand;

  assign read_dir1 = in_rs1;
  assign read_dir2 = in_rs2;

  // Hazard detection and operand resolution; a writeback landing this cycle
  // both supplies the data and releases the pending entry.
  always_comb begin
    wb_live     = wb_en && (wb_dir != '0);
    hit_rs1     = wb_live && (wb_dir == in_rs1);
    hit_rs2     = wb_live && (wb_dir == in_rs2);
    hit_rd      = wb_live && (wb_dir == in_rd);
    rs1_operand = (in_rs1 == '0) ? '0 : (hit_rs1 ? wb_data : read_data1);
    rs2_operand = (in_rs2 == '0) ? '0 : (hit_rs2 ? wb_data : read_data2);
    raw_hazard  = (in_use_rs1 && busy_q[in_rs1] && !hit_rs1) ||
                  (in_use_rs2 && busy_q[in_rs2] && !hit_rs2);
    waw_hazard  = in_rd_we && (in_rd != '0) && busy_q[in_rd] && !hit_rd;
    hazard      = raw_hazard || waw_hazard;
    space       = !out_valid_q || out_ready;
    in_ready    = space && !hazard;
    accept      = in_valid && in_ready;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    ctrl_d      = ctrl_q;
    busy_d      = busy_q;
    stall_d     = stall_q;

    if (accept) begin
      out_valid_d = 1'b1;
      rs1_data_d  = rs1_operand;
      rs2_data_d  = rs2_operand;
      rd_d        = in_rd;
      rd_we_d     = in_rd_we;
      ctrl_d      = in_ctrl;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear before set so a same-cycle retire and re-claim leaves the entry busy.
    if (wb_live) begin
      busy_d[wb_dir] = 1'b0;
    end
    if (accept && in_rd_we && (in_rd != '0)) begin
      busy_d[in_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    if (in_valid && hazard && (stall_q != '1)) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      ctrl_q      <= '0;
      stall_q     <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      ctrl_q      <= ctrl_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rs1_data = rs1_data_q;
  assign out_rs2_data = rs2_data_q;
  assign out_rd       = rd_q;
  assign out_rd_we    = rd_we_q;
  assign out_ctrl     = ctrl_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_register_read_stage.sv
// Bench for register_read_stage: directed scenarios plus randomized traffic
// checked against a scoreboard/slot model built from the operand-fetch rules.
module tb_register_read_stage;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_rd_we;
  logic [15:0] in_ctrl;
  logic [4:0]  read_dir1, read_dir2;
  logic [31:0] read_data1, read_data2;
  logic        wb_en;
  logic [4:0]  wb_dir;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1_data, out_rs2_data;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [15:0] out_ctrl;
  logic [15:0] stall_cycles;

  logic [31:0] rf [32];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign read_data1 = rf[read_dir1];
  assign read_data2 = rf[read_dir2];

  register_read_stage #(.DIR_WIDTH(5), .DATA_WIDTH(32), .CTRL_WIDTH(16)) dut (
    .clk(clk), .arst_n(arst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_ctrl(in_ctrl),
    .read_dir1(read_dir1), .read_dir2(read_dir2),
    .read_data1(read_data1), .read_data2(read_data2),
    .wb_en(wb_en), .wb_dir(wb_dir), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_ctrl(out_ctrl),
    .stall_cycles(stall_cycles)
  );

  // Advance one clock; the bench register file commits writebacks after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_en && wb_dir != 5'd0) rf[wb_dir] = wb_data;
  endtask

  task automatic idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_use_rs1 = 0; in_use_rs2 = 0;
    in_rd = 0; in_rd_we = 0; in_ctrl = 0;
    wb_en = 0; wb_dir = 0; wb_data = 0; out_ready = 1;
  endtask

  task automatic apply_reset();
    idle();
    arst_n = 0;
    tick();
    tick();
    arst_n = 1;
    tick();
  endtask

  task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we,
                       input logic [15:0] ctrl);
    in_valid = 1; in_rs1 = rs1; in_use_rs1 = u1; in_rs2 = rs2; in_use_rs2 = u2;
    in_rd = rd; in_rd_we = we; in_ctrl = ctrl;
  endtask

  task automatic test_reset();
    idle();
    arst_n = 0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_rs1_data !== 32'd0 || out_rs2_data !== 32'd0) begin n_err++; $display("FAIL reset_operands: got %h/%h want 0/0", out_rs1_data, out_rs2_data); end
    n_cmp++; if (out_rd !== 5'd0 || out_rd_we !== 1'b0 || out_ctrl !== 16'd0) begin n_err++; $display("FAIL reset_ctrl: got rd=%h we=%b ctrl=%h want 0", out_rd, out_rd_we, out_ctrl); end
    n_cmp++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL reset_stall: got %h want 0", stall_cycles); end
    arst_n = 1;
    tick();
  endtask

  task automatic test_basic_and_bypass();
    apply_reset();
    rf[3] = 32'd7; rf[4] = 32'd9;
    instr(5'd3, 1, 5'd4, 1, 5'd5, 1, 16'hA5A5);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", in_ready); end
    n_cmp++; if (read_dir1 !== 5'd3 || read_dir2 !== 5'd4) begin n_err++; $display("FAIL read_dir: got %h/%h want 3/4", read_dir1, read_dir2); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_rs1_data !== 32'd7 || out_rs2_data !== 32'd9) begin n_err++; $display("FAIL basic_out: got v=%b %h/%h want 1 7/9", out_valid, out_rs1_data, out_rs2_data); end
    n_cmp++; if (out_rd !== 5'd5 || out_rd_we !== 1'b1 || out_ctrl !== 16'hA5A5) begin n_err++; $display("FAIL basic_ctrl: got rd=%h we=%b ctrl=%h want 5 1 a5a5", out_rd, out_rd_we, out_ctrl); end
    // Dependent on r5 with no writeback: must stall.
    instr(5'd5, 1, 5'd0, 0, 5'd7, 0, 16'h0001);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall_ready: got %b want 0", in_ready); end
    tick();
    n_cmp++; if (stall_cycles !== 16'd1 || out_valid !== 1'b0) begin n_err++; $display("FAIL raw_stall_count: got cnt=%h v=%b want 1 0", stall_cycles, out_valid); end
    wb_en = 1; wb_dir = 5'd5; wb_data = 32'h10;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bypass_ready: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h10 || stall_cycles !== 16'd1) begin n_err++; $display("FAIL bypass_out: got v=%b %h cnt=%h want 1 10 1", out_valid, out_rs1_data, stall_cycles); end
    wb_en = 0;
    instr(5'd5, 1, 5'd0, 0, 5'd0, 0, 16'h0002);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL busy5_cleared: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_rs1_data !== 32'h10) begin n_err++; $display("FAIL rf_readback: got %h want 10", out_rs1_data); end
    idle();
  endtask

  task automatic test_zero_reg();
    apply_reset();
    instr(5'd0, 1, 5'd0, 1, 5'd0, 1, 16'h0F0F);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_rs1_data !== 32'd0 || out_rs2_data !== 32'd0) begin n_err++; $display("FAIL zero_operands: got %h/%h want 0/0", out_rs1_data, out_rs2_data); end
    wb_en = 1; wb_dir = 5'd0; wb_data = 32'h55;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL zero_busy: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_rs1_data !== 32'd0 || stall_cycles !== 16'd0) begin n_err++; $display("FAIL zero_wb_bypass: got %h cnt=%h want 0 0", out_rs1_data, stall_cycles); end
    idle();
  endtask

  task automatic test_backpressure();
    apply_reset();
    rf[3] = 32'd7; rf[4] = 32'd9;
    instr(5'd3, 1, 5'd4, 1, 5'd8, 1, 16'h1234);
    tick();
    out_ready = 0;
    instr(5'd1, 1, 5'd2, 1, 5'd9, 0, 16'h4321);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_rs1_data !== 32'd7 || out_rs2_data !== 32'd9 || out_rd !== 5'd8 || out_ctrl !== 16'h1234)
        begin n_err++; $display("FAIL hold_out[%0d]: got v=%b %h/%h rd=%h ctrl=%h want 1 7/9 8 1234", i, out_valid, out_rs1_data, out_rs2_data, out_rd, out_ctrl); end
    end
    n_cmp++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL hold_stall: got %h want 0", stall_cycles); end
    in_valid = 0; out_ready = 1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain: got %b want 0", out_valid); end
    idle();
  endtask

  task automatic test_waw();
    apply_reset();
    instr(5'd0, 0, 5'd0, 0, 5'd6, 1, 16'h0006);
    tick();
    instr(5'd0, 0, 5'd0, 0, 5'd6, 1, 16'h0066);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall: got %b want 0", in_ready); end
    tick();
    n_cmp++; if (stall_cycles !== 16'd1) begin n_err++; $display("FAIL waw_count: got %h want 1", stall_cycles); end
    wb_en = 1; wb_dir = 5'd6; wb_data = 32'hABCD;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL waw_wb_ready: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd6 || out_ctrl !== 16'h0066) begin n_err++; $display("FAIL waw_accept: got v=%b rd=%h ctrl=%h want 1 6 0066", out_valid, out_rd, out_ctrl); end
    wb_en = 0;
    instr(5'd6, 1, 5'd0, 0, 5'd0, 0, 16'h0000);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL waw_still_busy: got %b want 0", in_ready); end
    idle();
  endtask

  task automatic test_async_reset();
    apply_reset();
    instr(5'd0, 0, 5'd0, 0, 5'd5, 1, 16'h0005);
    tick();
    in_valid = 0; out_ready = 0;
    #2;
    arst_n = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_ctrl !== 16'd0) begin n_err++; $display("FAIL async_reset: got v=%b rd=%h ctrl=%h want 0 0 0", out_valid, out_rd, out_ctrl); end
    tick();
    arst_n = 1;
    out_ready = 1;
    instr(5'd5, 1, 5'd0, 0, 5'd0, 0, 16'h0055);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_ctrl !== 16'h0055) begin n_err++; $display("FAIL post_reset_accept: got v=%b ctrl=%h want 1 0055", out_valid, out_ctrl); end
    idle();
  endtask

  task automatic test_saturation();
    apply_reset();
    instr(5'd0, 0, 5'd0, 0, 5'd6, 1, 16'h0000);
    tick();
    instr(5'd6, 1, 5'd0, 0, 5'd0, 0, 16'h0000);
    for (int i = 0; i < 65534; i++) tick();
    n_cmp++; if (stall_cycles !== 16'hFFFE) begin n_err++; $display("FAIL sat_near: got %h want fffe", stall_cycles); end
    tick(); tick(); tick();
    n_cmp++; if (stall_cycles !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", stall_cycles); end
    idle();
  endtask

  task automatic test_random();
    bit          m_busy [32];
    bit          m_ov;
    logic [31:0] m_d1, m_d2;
    logic [4:0]  m_rd;
    logic        m_we;
    logic [15:0] m_ctrl;
    int          m_stall;
    bit          h1, h2, hd, haz, exp_ready, acc;
    logic [31:0] e1, e2;

    apply_reset();
    foreach (m_busy[r]) m_busy[r] = 0;
    m_ov = 0; m_d1 = 0; m_d2 = 0; m_rd = 0; m_we = 0; m_ctrl = 0; m_stall = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_rs1     = 5'($urandom_range(0, 7));
      in_rs2     = 5'($urandom_range(0, 7));
      in_rd      = 5'($urandom_range(0, 7));
      in_use_rs1 = 1'($urandom_range(0, 1));
      in_use_rs2 = 1'($urandom_range(0, 1));
      in_rd_we   = 1'($urandom_range(0, 1));
      in_ctrl    = 16'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      wb_en      = ($urandom_range(0, 2) == 0);
      wb_dir     = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      #1;
      h1  = wb_en && wb_dir == in_rs1 && in_rs1 != 0;
      h2  = wb_en && wb_dir == in_rs2 && in_rs2 != 0;
      hd  = wb_en && wb_dir == in_rd && in_rd != 0;
      haz = (in_use_rs1 && m_busy[in_rs1] && !h1) || (in_use_rs2 && m_busy[in_rs2] && !h2) ||
            (in_rd_we && in_rd != 0 && m_busy[in_rd] && !hd);
      exp_ready = (!m_ov || out_ready) && !haz;
      acc = in_valid && exp_ready;
      e1 = (in_rs1 == 0) ? 32'd0 : (h1 ? wb_data : rf[in_rs1]);
      e2 = (in_rs2 == 0) ? 32'd0 : (h2 ? wb_data : rf[in_rs2]);
      n_cmp++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, in_ready, exp_ready); end
      tick();
      if (acc) begin
        m_ov = 1; m_d1 = e1; m_d2 = e2; m_rd = in_rd; m_we = in_rd_we; m_ctrl = in_ctrl;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (wb_en && wb_dir != 0) m_busy[wb_dir] = 0;
      if (acc && in_rd_we && in_rd != 0) m_busy[in_rd] = 1;
      if (in_valid && haz && m_stall < 65535) m_stall++;
      n_cmp++; if (out_valid !== m_ov) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, out_valid, m_ov); end
      if (m_ov) begin
        n_cmp++;
        if (out_rs1_data !== m_d1 || out_rs2_data !== m_d2 || out_rd !== m_rd || out_rd_we !== m_we || out_ctrl !== m_ctrl) begin
          n_err++;
          $display("FAIL rnd_slot[%0d]: got %h/%h rd=%h we=%b ctrl=%h want %h/%h rd=%h we=%b ctrl=%h", cyc,
                   out_rs1_data, out_rs2_data, out_rd, out_rd_we, out_ctrl, m_d1, m_d2, m_rd, m_we, m_ctrl);
        end
      end
      n_cmp++; if (stall_cycles !== 16'(m_stall)) begin n_err++; $display("FAIL rnd_stall[%0d]: got %h want %h", cyc, stall_cycles, 16'(m_stall)); end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEAD_BEEF;
    idle();
    arst_n = 1;
    test_reset();
    test_basic_and_bypass();
    test_zero_reg();
    test_backpressure();
    test_waw();
    test_async_reset();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
